seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIGITS_PER_BANK, default 4, number of digits per bank (min 2); total digits N = 2*DIGITS_PER_BANK.
REQ-002 Parameter SCAN_DIV, default 100000, clk cycles per digit scan slot (min 2).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  display enable; 0 forces all segment/digit outputs to 0, scanning continues.
REQ-006 clr  input  1  one-cycle pulse, blanks all N digit entries.
REQ-007 wr_en  input  1  write one digit entry.
REQ-008 wr_addr  input  clog2(N)  entry index; 0 = leftmost digit of left bank, N-1 = rightmost digit of right bank.
REQ-009 wr_raw  input  1  0: wr_data[3:0] is a hex value to decode; 1: wr_data is a raw segment pattern.
REQ-010 wr_data  input  8  hex value or raw pattern {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp.
REQ-011 wr_dp  input  1  ORed into bit0 of the stored pattern.
REQ-012 shift_en  input  1  scroll: shift all entries one position left, new entry enters at N-1.
REQ-013 a_to_g_left  output  8  left-bank segments, active-high, same bit order as wr_data.
REQ-014 a_to_g_right  output  8  right-bank segments, active-high.
REQ-015 leftseg  output  DIGITS_PER_BANK  left-bank digit select, one-hot active-high, MSB = leftmost digit.
REQ-016 rightseg  output  DIGITS_PER_BANK  right-bank digit select, same convention.
REQ-017 frame_tick  output  1  one-cycle pulse when scan index wraps to 0.

Function
REQ-018 Each entry SHALL hold an 8-bit pattern and a valid bit; an invalid entry is blank.
REQ-019 Hex decode SHALL be: 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E (hex); wr_data[7:4] is ignored when wr_raw=0.
REQ-020 Decode happens at write time; the stored pattern is decode(wr_data) or wr_data, ORed with wr_dp, valid=1.
REQ-021 Write SHALL take effect on the next rising edge; wr_addr >= N SHALL be ignored.
REQ-022 Shift: entry[i] <= entry[i+1] for i < N-1, entry[N-1] <= the new pattern built as in REQ-020; entry[0] is discarded.
REQ-023 Priority in the same cycle: clr > shift_en > wr_en; the lower-priority request is dropped, not queued.
REQ-024 Prescaler counts 0..SCAN_DIV-1 and wraps; at count SCAN_DIV-1, scan index k advances by 1 and wraps from DIGITS_PER_BANK-1 to 0.
REQ-025 frame_tick SHALL be 1 for exactly the cycle in which k changes from DIGITS_PER_BANK-1 to 0.
REQ-026 Both banks scan in lockstep: left shows entry k, right shows entry DIGITS_PER_BANK+k.
REQ-027 Outputs SHALL be registered and reflect k and memory one cycle after the change; a write is visible at most one cycle after it lands, if its digit is selected.
REQ-028 For a blank entry, or when en=0, the bank's segment bus and digit select SHALL both be 0.
REQ-029 For a valid entry with en=1, the digit select bit DIGITS_PER_BANK-1-k is 1 and all other bits are 0.

Reset
REQ-030 While rst_n=0: prescaler=0, k=0, all entries blank, all outputs 0, frame_tick=0.
REQ-031 Reset mid-scan or mid-write aborts immediately; no partial write survives.
REQ-032 After deassertion, the first k advance occurs SCAN_DIV cycles later.

Structure
REQ-033 Shared package seg_pkg holds the segment bit-position constants, the 16-entry hex pattern table, and the blank pattern 8'h00.
REQ-034 Hex decode SHALL be a combinational sub-module seg_hex_decode (4-bit in, 8-bit out), instantiated once on the write/shift path.
REQ-035 There is one prescaler, one scan counter, and an N-entry register file; no additional clock domains.

Verification (SCAN_DIV=4, DIGITS_PER_BANK=4)
REQ-036 Write hex 2,0,2,3 to entries 0..3 and raw 60,DB,DA,DA to entries 4..7, en=1 -> per slot: left DA/1000, FC/0100, DA/0010, F2/0001; right 60/1000, DB/0100, DA/0010, DA/0001.
REQ-037 Run 16 cycles after reset -> k changes every 4 cycles; frame_tick pulses once, at cycle 16.
REQ-038 Leave entry 5 blank, rest valid -> in slot k=1, a_to_g_right=00 and rightseg=0000, while the left bank is unaffected.
REQ-039 Assert shift_en, wr_raw=0, wr_data=7 while entries hold 0..7 -> entries become 1..7,7; the same cycle with wr_en=1 to addr 0 drops the write.
REQ-040 Assert clr and wr_en together, then en=0 -> all entries blank; all outputs 0 while scanning and frame_tick continue.
REQ-041 Assert rst_n=0 mid-slot with k=2 -> outputs 0 immediately (asynchronously); after release k=0 and the first advance comes 4 cycles later.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared segment constants for the scanned seven-segment driver: bit positions,
// blank pattern, hex glyph table and the register-file entry layout.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Glyphs {a,b,c,d,e,f,g,dp}; b and d are lowercase so they differ from 8 and 0.
  localparam logic [7:0] HEX_TABLE [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  typedef struct packed {
    logic       vld;
    logic [7:0] pat;
  } entry_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder used on the write/shift path.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  // Table lookup; every 4-bit code has a glyph.
  always_comb begin
    seg = HEX_TABLE[hex];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-bank multiplexed seven-segment driver: N-entry pattern store with write,
// scroll and clear, plus a shared prescaler and scan index driving both banks.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS_PER_BANK = 4,
  parameter int SCAN_DIV        = 100000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 clr,
  input  logic                                 wr_en,
  input  logic [$clog2(2*DIGITS_PER_BANK)-1:0] wr_addr,
  input  logic                                 wr_raw,
  input  logic [7:0]                           wr_data,
  input  logic                                 wr_dp,
  input  logic                                 shift_en,
  output logic [7:0]                           a_to_g_left,
  output logic [7:0]                           a_to_g_right,
  output logic [DIGITS_PER_BANK-1:0]           leftseg,
  output logic [DIGITS_PER_BANK-1:0]           rightseg,
  output logic                                 frame_tick
);

  localparam int N  = 2 * DIGITS_PER_BANK;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int KW = $clog2(DIGITS_PER_BANK);
  localparam logic [DIGITS_PER_BANK-1:0] SEL_MSB = {1'b1, {(DIGITS_PER_BANK-1){1'b0}}};

  logic [CW-1:0]              cnt_r;
  logic [KW-1:0]              k_r;
  entry_t                     mem_r     [N];
  entry_t                     mem_nxt_s [N];
  logic [7:0]                 dec_s;
  logic [7:0]                 new_pat_s;
  logic                       slot_end_s;
  logic                       k_wrap_s;
  entry_t                     left_ent_s;
  entry_t                     right_ent_s;
  logic [7:0]                 left_seg_s;
  logic [7:0]                 right_seg_s;
  logic [DIGITS_PER_BANK-1:0] left_sel_s;
  logic [DIGITS_PER_BANK-1:0] right_sel_s;

  seg_hex_decode u_dec (
    .hex (wr_data[3:0]),
    .seg (dec_s)
  );

  // Pattern entering the store, shared by direct writes and scroll-in.
  always_comb begin
    new_pat_s         = wr_raw ? wr_data : dec_s;
    new_pat_s[SEG_DP] = new_pat_s[SEG_DP] | wr_dp;
  end

  assign slot_end_s = (cnt_r == CW'(SCAN_DIV - 1));
  assign k_wrap_s   = (k_r == KW'(DIGITS_PER_BANK - 1));

  // Prescaler and scan index; k only moves on the last prescaler count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      k_r   <= '0;
    end else if (slot_end_s) begin
      cnt_r <= '0;
      k_r   <= k_wrap_s ? KW'(0) : k_r + KW'(1);
    end else begin
      cnt_r <= cnt_r + CW'(1);
      k_r   <= k_r;
    end
  end

  // Store update; lower-priority requests in the same cycle are dropped.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mem_nxt_s[i] = mem_r[i];
    end
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        mem_nxt_s[i] = '{vld: 1'b0, pat: SEG_BLANK};
      end
    end else if (shift_en) begin
      for (int i = 0; i < N - 1; i++) begin
        mem_nxt_s[i] = mem_r[i+1];
      end
      mem_nxt_s[N-1] = '{vld: 1'b1, pat: new_pat_s};
    end else if (wr_en && (32'(wr_addr) < N)) begin
      mem_nxt_s[wr_addr] = '{vld: 1'b1, pat: new_pat_s};
    end else begin
      mem_nxt_s[0] = mem_r[0];
    end
  end

  // Register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= '{vld: 1'b0, pat: SEG_BLANK};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= mem_nxt_s[i];
      end
    end
  end

  assign left_ent_s  = mem_r[AW'(k_r)];
  assign right_ent_s = mem_r[AW'(k_r) + AW'(DIGITS_PER_BANK)];

  // Per-bank drive: blank entries and a disabled display turn the digit fully off.
  always_comb begin
    left_seg_s  = SEG_BLANK;
    left_sel_s  = '0;
    right_seg_s = SEG_BLANK;
    right_sel_s = '0;
    if (en && left_ent_s.vld) begin
      left_seg_s = left_ent_s.pat;
      left_sel_s = SEL_MSB >> k_r;
    end else begin
      left_seg_s = SEG_BLANK;
    end
    if (en && right_ent_s.vld) begin
      right_seg_s = right_ent_s.pat;
      right_sel_s = SEL_MSB >> k_r;
    end else begin
      right_seg_s = SEG_BLANK;
    end
  end

  // Output registers; frame_tick coincides with k wrapping to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_to_g_left  <= SEG_BLANK;
      a_to_g_right <= SEG_BLANK;
      leftseg      <= '0;
      rightseg     <= '0;
      frame_tick   <= 1'b0;
    end else begin
      a_to_g_left  <= left_seg_s;
      a_to_g_right <= right_seg_s;
      leftseg      <= left_sel_s;
      rightseg     <= right_sel_s;
      frame_tick   <= slot_end_s && k_wrap_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (SCAN_DIV=4, DIGITS_PER_BANK=4): directed and random
// stimulus checked every cycle against a cycle-count based reference model.
module tb_seg_scan_driver;

  localparam int D   = 4;
  localparam int DIV = 4;
  localparam int N   = 2 * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic       wr_raw = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_dp = 1'b0;
  logic       shift_en = 1'b0;
  logic [7:0] a_to_g_left, a_to_g_right;
  logic [3:0] leftseg, rightseg;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;

  // Reference model: contents of each digit and edges seen since reset release.
  logic [7:0] m_pat [N];
  bit         m_vld [N];
  int         nedge;
  logic [7:0] hex_glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  seg_scan_driver #(.DIGITS_PER_BANK(D), .SCAN_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_raw(wr_raw), .wr_data(wr_data), .wr_dp(wr_dp), .shift_en(shift_en),
    .a_to_g_left(a_to_g_left), .a_to_g_right(a_to_g_right),
    .leftseg(leftseg), .rightseg(rightseg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, nedge);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_segl"}, a_to_g_left, 8'h00);
    chk({tag, "_segr"}, a_to_g_right, 8'h00);
    chk({tag, "_sell"}, {4'h0, leftseg}, 8'h00);
    chk({tag, "_selr"}, {4'h0, rightseg}, 8'h00);
    chk({tag, "_tick"}, {7'h0, frame_tick}, 8'h00);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0;
      m_pat[i] = 8'h00;
    end
  endtask

  // One clock with the currently driven inputs; predicts and checks all outputs.
  task automatic step();
    int k;
    logic [7:0] e_l, e_r, np;
    logic [3:0] e_ls, e_rs;
    logic e_ft;
    k    = (nedge / DIV) % D;
    e_l  = (en && m_vld[k])     ? m_pat[k]       : 8'h00;
    e_ls = (en && m_vld[k])     ? (4'b1000 >> k) : 4'h0;
    e_r  = (en && m_vld[k + D]) ? m_pat[k + D]   : 8'h00;
    e_rs = (en && m_vld[k + D]) ? (4'b1000 >> k) : 4'h0;
    e_ft = ((nedge + 1) % (DIV * D)) == 0;
    np = wr_raw ? wr_data : hex_glyph[wr_data[3:0]];
    np[0] = np[0] | wr_dp;
    if (clr) begin
      model_clear();
    end else if (shift_en) begin
      for (int i = 0; i < N - 1; i++) begin
        m_pat[i] = m_pat[i + 1];
        m_vld[i] = m_vld[i + 1];
      end
      m_pat[N - 1] = np;
      m_vld[N - 1] = 1'b1;
    end else if (wr_en) begin
      m_pat[wr_addr] = np;
      m_vld[wr_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    nedge++;
    chk("seg_left",  a_to_g_left,       e_l);
    chk("seg_right", a_to_g_right,      e_r);
    chk("sel_left",  {4'h0, leftseg},   {4'h0, e_ls});
    chk("sel_right", {4'h0, rightseg},  {4'h0, e_rs});
    chk("frame_tick", {7'h0, frame_tick}, {7'h0, e_ft});
  endtask

  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; shift_en = 1'b0; wr_raw = 1'b0; wr_dp = 1'b0;
    wr_data = 8'h00; wr_addr = 3'd0;
  endtask

  task automatic wr(input logic [2:0] a, input logic raw, input logic [7:0] d, input logic dp);
    idle();
    wr_en = 1'b1; wr_addr = a; wr_raw = raw; wr_data = d; wr_dp = dp;
    step();
    idle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset from the middle of a clock period.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero(tag);
    model_clear();
    @(posedge clk);
    #1;
    chk_all_zero({tag, "_held"});
    rst_n = 1'b1;
    nedge = 0;
  endtask

  initial begin
    logic [7:0] raw_pats [4] = '{8'h60, 8'hDB, 8'hDA, 8'hDA};
    logic [3:0] hex_vals [4] = '{4'h2, 4'h0, 4'h2, 4'h3};
    int guard;
    nedge = 0;
    model_clear();
    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty store: only frame_tick moves, on edge 16.
    run(20);

    // Hex 2,0,2,3 on the left bank, raw patterns on the right.
    for (int i = 0; i < 4; i++) wr(3'(i), 1'b0, {4'hA, hex_vals[i]}, 1'b0);
    for (int i = 0; i < 4; i++) wr(3'(i + 4), 1'b1, raw_pats[i], 1'b0);
    run(16);

    // Entry 5 blank, others valid with decimal points.
    idle(); clr = 1'b1; step(); idle();
    for (int i = 0; i < N; i++) begin
      if (i != 5) wr(3'(i), 1'b0, 8'(i + 8), 1'b1);
    end
    run(16);

    // Scroll with a competing write that must be dropped.
    for (int i = 0; i < N; i++) wr(3'(i), 1'b0, 8'(i), 1'b0);
    idle(); shift_en = 1'b1; wr_data = 8'h07; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h07;
    step(); idle();
    run(16);

    // Clear beats write, then display disabled while scanning continues.
    idle(); clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h05; step(); idle();
    wr(3'd1, 1'b1, 8'hFF, 1'b0);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(4);

    // Random traffic with overlapping requests.
    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(0, 19) == 0);
      shift_en = ($urandom_range(0, 5) == 0);
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_raw   = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom_range(0, 255));
      wr_dp    = 1'($urandom_range(0, 1));
      en       = ($urandom_range(0, 7) != 0);
      step();
    end
    idle();
    en = 1'b1;

    // Fill, then reset mid-slot with k=2.
    for (int i = 0; i < N; i++) wr(3'(i), 1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    guard = 0;
    while (!(((nedge / DIV) % D == 2) && (nedge % DIV == 1)) && guard < 64) begin
      step();
      guard++;
    end
    chk("reach_k2", {7'h0, guard < 64}, 8'h01);
    do_reset("midslot_reset");
    wr(3'd0, 1'b1, 8'h81, 1'b0);
    wr(3'd4, 1'b0, 8'h0E, 1'b1);
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
